// File: rtl/mc_seq.sv
// Multi-cycle instruction sequencer for the MIPS datapath.
// Each instruction passes through FETCH / DECODE / EXEC / MEM / WB. The
// sequencer drives the register and memory enables for each step. It runs a
// req/ack handshake to data memory, with a timeout that traps into ERR. It
// also keeps counters of retired instructions and of active cycles.
// ALUOp, EXTOp, ASel and BSel still come from the separate ctrl block.
module mc_seq #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dm_ack,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             ir_wr,
    output logic             ab_wr,
    output logic             alu_out_wr,
    output logic             mdr_wr,
    output logic             dm_req,
    output logic             dm_we,
    output logic             rf_wr,
    output logic [1:0]       wd_sel,
    output logic [1:0]       gpr_sel,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // pc_src encodings
    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    // wd_sel / gpr_sel encodings
    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_MDR  = 2'd1;
    localparam logic [1:0] WD_LINK = 2'd2;
    localparam logic [1:0] GS_RD   = 2'd0;
    localparam logic [1:0] GS_RT   = 2'd1;
    localparam logic [1:0] GS_RA   = 2'd2;

    // Value the wait counter holds in the last MEM cycle allowed without an ack
    localparam logic [7:0]       TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t     cur;
    state_t     nxt;
    logic [7:0] tmo_cnt;
    logic       tmo_clr;
    logic       tmo_inc;
    logic       tmo_fire;

    // Instruction class decode from the IR fields
    logic is_rtype;
    logic is_j;
    logic is_jal;
    logic is_beq;
    logic is_bne;
    logic is_jr;
    logic is_ialu;
    logic is_lw;
    logic is_sw;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_bne   = (opcode == OP_BNE);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_ialu  = (opcode == OP_ADDIU) || (opcode == OP_SLTI) ||
                      (opcode == OP_ORI)   || (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);

    assign state = cur;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // MEM wait counter: cleared on the way into MEM, counts cycles without an ack
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= 8'd0;
        end else if (tmo_clr) begin
            tmo_cnt <= 8'd0;
        end else if (tmo_inc) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Sticky bus error, set when a MEM access runs out of wait cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (tmo_fire) begin
            bus_err <= 1'b1;
        end
    end

    // Retired-instruction and active-cycle counters, both free-running and wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt <= '0;
            cyc_cnt   <= '0;
        end else begin
            if (instr_done) begin
                instr_cnt <= instr_cnt + CNT_ONE;
            end
            if ((cur != S_IDLE) && (cur != S_ERR)) begin
                cyc_cnt <= cyc_cnt + CNT_ONE;
            end
        end
    end

    // Next-state and enable decode; an instruction end picks FETCH or IDLE from run
    always_comb begin
        nxt        = cur;
        pc_wr      = 1'b0;
        pc_src     = PC_SEQ;
        ir_wr      = 1'b0;
        ab_wr      = 1'b0;
        alu_out_wr = 1'b0;
        mdr_wr     = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        rf_wr      = 1'b0;
        wd_sel     = WD_ALU;
        gpr_sel    = GS_RD;
        instr_done = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        tmo_fire   = 1'b0;

        case (cur)
            S_IDLE: begin
                if (run) begin
                    nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                ir_wr  = 1'b1;
                pc_wr  = 1'b1;
                pc_src = PC_SEQ;
                nxt    = S_DECODE;
            end

            S_DECODE: begin
                ab_wr = 1'b1;
                if (is_j || is_jal) begin
                    pc_wr      = 1'b1;
                    pc_src     = PC_JUMP;
                    instr_done = 1'b1;
                    if (is_jal) begin
                        // PC already holds PC+4 from FETCH, which is the link value
                        rf_wr   = 1'b1;
                        wd_sel  = WD_LINK;
                        gpr_sel = GS_RA;
                    end
                end else begin
                    nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_out_wr = 1'b1;
                if (is_beq) begin
                    pc_wr      = zero;
                    pc_src     = PC_BRANCH;
                    instr_done = 1'b1;
                end else if (is_bne) begin
                    pc_wr      = ~zero;
                    pc_src     = PC_BRANCH;
                    instr_done = 1'b1;
                end else if (is_jr) begin
                    pc_wr      = 1'b1;
                    pc_src     = PC_REG;
                    instr_done = 1'b1;
                end else if (is_rtype || is_ialu) begin
                    nxt = S_WB;
                end else if (is_lw || is_sw) begin
                    tmo_clr = 1'b1;
                    nxt     = S_MEM;
                end else begin
                    // Unknown opcode: retire as a nop with no architectural writes
                    instr_done = 1'b1;
                end
            end

            S_MEM: begin
                dm_req = 1'b1;
                dm_we  = is_sw;
                if (dm_ack) begin
                    if (is_sw) begin
                        instr_done = 1'b1;
                    end else begin
                        mdr_wr = 1'b1;
                        nxt    = S_WB;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire = 1'b1;
                    nxt      = S_ERR;
                end else begin
                    tmo_inc = 1'b1;
                end
            end

            S_WB: begin
                rf_wr      = 1'b1;
                instr_done = 1'b1;
                wd_sel     = is_lw ? WD_MDR : WD_ALU;
                gpr_sel    = is_rtype ? GS_RD : GS_RT;
            end

            S_ERR: begin
                nxt = S_ERR;
            end

            default: begin
                nxt = S_IDLE;
            end
        endcase

        // run is only looked at between instructions, never mid-instruction
        if (instr_done) begin
            nxt = run ? S_FETCH : S_IDLE;
        end
    end

endmodule
